// File: rtl/alu_pkg.sv
// Shared ALU definitions: widths, opcode encodings and the legality check
// used by both the ALU and the arbiter that wraps it.
package alu_pkg;

  localparam int W   = 32;
  localparam int OPW = 4;

  localparam logic [OPW-1:0] ALUOP_AND = 4'b0000;
  localparam logic [OPW-1:0] ALUOP_OR  = 4'b0001;
  localparam logic [OPW-1:0] ALUOP_ADD = 4'b0010;
  localparam logic [OPW-1:0] ALUOP_LT  = 4'b0100;
  localparam logic [OPW-1:0] ALUOP_XOR = 4'b0101;
  localparam logic [OPW-1:0] ALUOP_SUB = 4'b0110;
  localparam logic [OPW-1:0] ALUOP_SRL = 4'b1000;
  localparam logic [OPW-1:0] ALUOP_SLL = 4'b1001;
  localparam logic [OPW-1:0] ALUOP_SRA = 4'b1010;

  function automatic logic is_legal_op(input logic [OPW-1:0] op);
    case (op)
      ALUOP_AND, ALUOP_OR, ALUOP_ADD, ALUOP_LT, ALUOP_XOR,
      ALUOP_SUB, ALUOP_SRL, ALUOP_SLL, ALUOP_SRA: is_legal_op = 1'b1;
      default:                                    is_legal_op = 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/alu_arbiter_if.sv
// Request/response bundle for the two ALU requesters. Handshake: a request on
// port i transfers in the cycle where req_valid_i & req_ready_i are both high;
// the requester holds valid and operands until then. Responses have no ready.
interface alu_arbiter_if;
  import alu_pkg::*;

  logic           req_valid_0;
  logic           req_valid_1;
  logic           req_ready_0;
  logic           req_ready_1;
  logic [W-1:0]   req_op1_0;
  logic [W-1:0]   req_op1_1;
  logic [W-1:0]   req_op2_0;
  logic [W-1:0]   req_op2_1;
  logic [OPW-1:0] req_alu_op_0;
  logic [OPW-1:0] req_alu_op_1;
  logic           rsp_valid_0;
  logic           rsp_valid_1;
  logic [W-1:0]   rsp_result;
  logic           rsp_zero;
  logic           rsp_illegal;

  modport master (
    output req_valid_0, req_valid_1, req_op1_0, req_op1_1,
           req_op2_0, req_op2_1, req_alu_op_0, req_alu_op_1,
    input  req_ready_0, req_ready_1, rsp_valid_0, rsp_valid_1,
           rsp_result, rsp_zero, rsp_illegal
  );

  modport slave (
    input  req_valid_0, req_valid_1, req_op1_0, req_op1_1,
           req_op2_0, req_op2_1, req_alu_op_0, req_alu_op_1,
    output req_ready_0, req_ready_1, rsp_valid_0, rsp_valid_1,
           rsp_result, rsp_zero, rsp_illegal
  );
endinterface

// File: rtl/alu_arbiter_alu.sv
// Purely combinational 32-bit ALU. Unknown opcodes produce 0; the arbiter
// separately flags them as illegal.
module alu_arbiter_alu
  import alu_pkg::*;
(
  input  logic [W-1:0]   op1_i,
  input  logic [W-1:0]   op2_i,
  input  logic [OPW-1:0] alu_op_i,
  output logic [W-1:0]   result_o,
  output logic           zero_o
);

  logic [4:0] shamt;
  assign shamt = op2_i[4:0];

  always_comb begin
    result_o = '0;
    case (alu_op_i)
      ALUOP_AND: result_o = op1_i & op2_i;
      ALUOP_OR:  result_o = op1_i | op2_i;
      ALUOP_ADD: result_o = op1_i + op2_i;
      ALUOP_SUB: result_o = op1_i - op2_i;
      ALUOP_LT:  result_o = {{(W-1){1'b0}}, ($signed(op1_i) < $signed(op2_i))};
      ALUOP_XOR: result_o = op1_i ^ op2_i;
      ALUOP_SRL: result_o = op1_i >> shamt;
      ALUOP_SLL: result_o = op1_i << shamt;
      ALUOP_SRA: result_o = $unsigned($signed(op1_i) >>> shamt);
      default:   result_o = '0;
    endcase
  end

  assign zero_o = (result_o == '0);

endmodule

// File: rtl/alu_arbiter.sv
// Two-port arbiter sharing one ALU, registered response one cycle after the
// handshake. Round-robin by default; define ALU_ARB_FIXED_PRIO_EN for port-0 priority.
module alu_arbiter
  import alu_pkg::*;
(
  input  logic          clk,
  input  logic          rst,
  alu_arbiter_if.slave  bus,
  output logic          last_grant_o
);

  logic [1:0]     gnt;
  logic           last_grant_q, last_grant_d;
  logic [1:0]     rsp_valid_q;
  logic [W-1:0]   rsp_result_q;
  logic           rsp_zero_q;
  logic           rsp_illegal_q;

  logic [W-1:0]   sel_op1;
  logic [W-1:0]   sel_op2;
  logic [OPW-1:0] sel_op;
  logic [W-1:0]   alu_result;
  logic           alu_zero;
  logic           sel_legal;

  always_comb begin
    gnt          = 2'b00;
    last_grant_d = last_grant_q;
    if (!rst) begin
`ifdef ALU_ARB_FIXED_PRIO_EN
      gnt[0] = bus.req_valid_0;
      gnt[1] = bus.req_valid_1 & ~bus.req_valid_0;
`else
      // On contention the port that did not win last time goes next.
      if (bus.req_valid_0 && bus.req_valid_1) begin
        gnt[0] = last_grant_q;
        gnt[1] = ~last_grant_q;
      end else begin
        gnt[0] = bus.req_valid_0;
        gnt[1] = bus.req_valid_1;
      end
`endif
      if (gnt[1])      last_grant_d = 1'b1;
      else if (gnt[0]) last_grant_d = 1'b0;
    end
  end

  assign bus.req_ready_0 = gnt[0];
  assign bus.req_ready_1 = gnt[1];

  assign sel_op1   = gnt[1] ? bus.req_op1_1    : bus.req_op1_0;
  assign sel_op2   = gnt[1] ? bus.req_op2_1    : bus.req_op2_0;
  assign sel_op    = gnt[1] ? bus.req_alu_op_1 : bus.req_alu_op_0;
  assign sel_legal = is_legal_op(sel_op);

  alu_arbiter_alu u_alu (
    .op1_i    (sel_op1),
    .op2_i    (sel_op2),
    .alu_op_i (sel_op),
    .result_o (alu_result),
    .zero_o   (alu_zero)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      rsp_valid_q   <= 2'b00;
      rsp_result_q  <= '0;
      rsp_zero_q    <= 1'b1;
      rsp_illegal_q <= 1'b0;
      last_grant_q  <= 1'b1;
    end else begin
      rsp_valid_q  <= gnt;
      last_grant_q <= last_grant_d;
      if (|gnt) begin
        rsp_result_q  <= sel_legal ? alu_result : '0;
        rsp_zero_q    <= sel_legal ? alu_zero : 1'b1;
        rsp_illegal_q <= ~sel_legal;
      end
    end
  end

  // A response pending when reset arrives must not be seen by the requester.
  assign bus.rsp_valid_0 = rsp_valid_q[0] & ~rst;
  assign bus.rsp_valid_1 = rsp_valid_q[1] & ~rst;
  assign bus.rsp_result  = rsp_result_q;
  assign bus.rsp_zero    = rsp_zero_q;
  assign bus.rsp_illegal = rsp_illegal_q;
  assign last_grant_o    = last_grant_q;

endmodule

// File: tb/tb_alu_arbiter.sv
// Directed bench for alu_arbiter: hand-computed vectors checked with immediate
// assertions; expectations follow ALU_ARB_FIXED_PRIO_EN when it is defined.
module tb_alu_arbiter;
  import alu_pkg::*;

  logic clk;
  logic rst;
  logic last_grant;
  int   n_checks;
  int   n_fail;

  alu_arbiter_if bus ();

  alu_arbiter dut (
    .clk          (clk),
    .rst          (rst),
    .bus          (bus.slave),
    .last_grant_o (last_grant)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input int p, input logic v, input logic [31:0] a,
                       input logic [31:0] b, input logic [3:0] op);
    if (p == 0) begin
      bus.req_valid_0 = v; bus.req_op1_0 = a; bus.req_op2_0 = b; bus.req_alu_op_0 = op;
    end else begin
      bus.req_valid_1 = v; bus.req_op1_1 = a; bus.req_op2_1 = b; bus.req_alu_op_1 = op;
    end
  endtask

  task automatic check_rsp(input string tag, input logic v0, input logic v1,
                           input logic [31:0] res, input logic z, input logic ill);
    check({tag, "_valid0"},  {31'd0, bus.rsp_valid_0}, {31'd0, v0});
    check({tag, "_valid1"},  {31'd0, bus.rsp_valid_1}, {31'd0, v1});
    check({tag, "_result"},  bus.rsp_result, res);
    check({tag, "_zero"},    {31'd0, bus.rsp_zero}, {31'd0, z});
    check({tag, "_illegal"}, {31'd0, bus.rsp_illegal}, {31'd0, ill});
  endtask

  initial begin
    int exp_g;
    int exp_lg;
    n_checks = 0;
    n_fail   = 0;
    rst = 1'b1;
    drive(0, 1'b0, 32'd0, 32'd0, ALUOP_ADD);
    drive(1, 1'b0, 32'd0, 32'd0, ALUOP_ADD);
    repeat (2) tick();

    // Reset state; ready stays low during reset even with a request present.
    drive(0, 1'b1, 32'd1, 32'd2, ALUOP_ADD);
    #1;
    check("rst_ready0", {31'd0, bus.req_ready_0}, 32'd0);
    check_rsp("rst", 1'b0, 1'b0, 32'd0, 1'b1, 1'b0);
    check("rst_last_grant", {31'd0, last_grant}, 32'd1);
    drive(0, 1'b0, 32'd0, 32'd0, ALUOP_ADD);
    rst = 1'b0;
    tick();

    // ADD 5 + 7 on port 0.
    drive(0, 1'b1, 32'd5, 32'd7, ALUOP_ADD);
    #1;
    check("add_ready0", {31'd0, bus.req_ready_0}, 32'd1);
    check("add_ready1", {31'd0, bus.req_ready_1}, 32'd0);
    tick();
    drive(0, 1'b0, 32'd0, 32'd0, ALUOP_ADD);
    check_rsp("add", 1'b1, 1'b0, 32'd12, 1'b0, 1'b0);
    check("add_last_grant", {31'd0, last_grant}, 32'd0);

    // Port 1 SRA and signed LT.
    drive(1, 1'b1, 32'h8000_0000, 32'd4, ALUOP_SRA);
    #1;
    check("sra_ready1", {31'd0, bus.req_ready_1}, 32'd1);
    tick();
    drive(1, 1'b1, 32'hFFFF_FFFF, 32'd1, ALUOP_LT);
    check_rsp("sra", 1'b0, 1'b1, 32'hF800_0000, 1'b0, 1'b0);
    tick();
    drive(1, 1'b0, 32'd0, 32'd0, ALUOP_ADD);
    check_rsp("lt", 1'b0, 1'b1, 32'd1, 1'b0, 1'b0);
    check("lt_last_grant", {31'd0, last_grant}, 32'd1);

    // Contention for 4 cycles: SUB 3-3 on port 0, XOR F0^0F on port 1.
    drive(0, 1'b1, 32'd3, 32'd3, ALUOP_SUB);
    drive(1, 1'b1, 32'hF0, 32'h0F, ALUOP_XOR);
    for (int i = 0; i < 4; i++) begin
`ifdef ALU_ARB_FIXED_PRIO_EN
      exp_g = 0;
`else
      exp_g = i % 2;
`endif
      #1;
      check("cont_ready0", {31'd0, bus.req_ready_0}, (exp_g == 0) ? 32'd1 : 32'd0);
      check("cont_ready1", {31'd0, bus.req_ready_1}, (exp_g == 1) ? 32'd1 : 32'd0);
      tick();
      if (i == 3) begin
        drive(0, 1'b0, 32'd0, 32'd0, ALUOP_ADD);
        drive(1, 1'b0, 32'd0, 32'd0, ALUOP_ADD);
      end
      if (exp_g == 0) check_rsp("cont_p0", 1'b1, 1'b0, 32'd0, 1'b1, 1'b0);
      else            check_rsp("cont_p1", 1'b0, 1'b1, 32'hFF, 1'b0, 1'b0);
    end
`ifdef ALU_ARB_FIXED_PRIO_EN
    exp_lg = 0;
`else
    exp_lg = 1;
`endif
    check("cont_last_grant", {31'd0, last_grant}, exp_lg[31:0]);

    // Illegal opcode, then a legal OR.
    drive(0, 1'b1, 32'h1234, 32'd5, 4'b1111);
    #1;
    check("ill_ready0", {31'd0, bus.req_ready_0}, 32'd1);
    tick();
    drive(0, 1'b1, 32'hA0, 32'h05, ALUOP_OR);
    check_rsp("ill", 1'b1, 1'b0, 32'd0, 1'b1, 1'b1);
    tick();
    drive(0, 1'b0, 32'd0, 32'd0, ALUOP_ADD);
    check_rsp("or", 1'b1, 1'b0, 32'hA5, 1'b0, 1'b0);

    // Idle cycle: response fields hold.
    tick();
    check_rsp("hold", 1'b0, 1'b0, 32'hA5, 1'b0, 1'b0);

    // Grant in N, reset in N+1: the response never appears.
    drive(0, 1'b1, 32'd1, 32'd1, ALUOP_ADD);
    #1;
    check("rif_ready0", {31'd0, bus.req_ready_0}, 32'd1);
    tick();
    drive(0, 1'b0, 32'd0, 32'd0, ALUOP_ADD);
    rst = 1'b1;
    #1;
    check("rif_valid0_in_rst", {31'd0, bus.rsp_valid_0}, 32'd0);
    tick();
    rst = 1'b0;
    check_rsp("rif_after", 1'b0, 1'b0, 32'd0, 1'b1, 1'b0);
    check("rif_last_grant", {31'd0, last_grant}, 32'd1);
    tick();
    check_rsp("rif_later", 1'b0, 1'b0, 32'd0, 1'b1, 1'b0);

    // First contention after reset goes to port 0.
    drive(0, 1'b1, 32'd9, 32'd1, ALUOP_ADD);
    drive(1, 1'b1, 32'd9, 32'd1, ALUOP_SUB);
    #1;
    check("post_rst_ready0", {31'd0, bus.req_ready_0}, 32'd1);
    check("post_rst_ready1", {31'd0, bus.req_ready_1}, 32'd0);
    tick();
    drive(0, 1'b0, 32'd0, 32'd0, ALUOP_ADD);
    drive(1, 1'b0, 32'd0, 32'd0, ALUOP_ADD);
    check_rsp("post_rst", 1'b1, 1'b0, 32'd10, 1'b0, 1'b0);

    // Port 1 alone, then port 1 loses to port 0 and abandons its request.
    drive(1, 1'b1, 32'd2, 32'd3, ALUOP_ADD);
    tick();
    drive(1, 1'b0, 32'd0, 32'd0, ALUOP_ADD);
    check_rsp("p1_alone", 1'b0, 1'b1, 32'd5, 1'b0, 1'b0);
    check("p1_alone_last_grant", {31'd0, last_grant}, 32'd1);
    drive(0, 1'b1, 32'hFF, 32'h0F, ALUOP_AND);
    drive(1, 1'b1, 32'h10, 32'h01, ALUOP_OR);
    #1;
    check("abn_ready0", {31'd0, bus.req_ready_0}, 32'd1);
    check("abn_ready1", {31'd0, bus.req_ready_1}, 32'd0);
    tick();
    drive(0, 1'b0, 32'd0, 32'd0, ALUOP_ADD);
    drive(1, 1'b0, 32'd0, 32'd0, ALUOP_ADD);
    #1;
    check("abn_ready1_dropped", {31'd0, bus.req_ready_1}, 32'd0);
    check_rsp("abn_p0", 1'b1, 1'b0, 32'h0F, 1'b0, 1'b0);
    check("abn_last_grant", {31'd0, last_grant}, 32'd0);
    tick();
    check_rsp("abn_idle", 1'b0, 1'b0, 32'h0F, 1'b0, 1'b0);
    check("abn_idle_last_grant", {31'd0, last_grant}, 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
